// File: rtl/sdram_pkg.sv
// sdram_pkg
// Shared definitions for the SDRAM controller slice.
//  - 5-bit command encodings {CKE,CS_N,RAS_N,CAS_N,WE_N}
//  - bit positions of the mode-register fields on the address bus
//  - the A10 index (auto-precharge / precharge-all select)
//  - state type of the power-up initialisation sequencer
package sdram_pkg;

    localparam logic [4:0] CMD_NOP  = 5'b10111;
    localparam logic [4:0] CMD_ACT  = 5'b10011;
    localparam logic [4:0] CMD_RD   = 5'b10101;
    localparam logic [4:0] CMD_WR   = 5'b10100;
    localparam logic [4:0] CMD_PREC = 5'b10010;
    localparam logic [4:0] CMD_AREF = 5'b10001;
    localparam logic [4:0] CMD_MRS  = 5'b10000;

    // Mode register field positions on the address bus
    localparam int MR_BL_LSB  = 0;
    localparam int MR_CAS_LSB = 4;
    localparam int MR_WB_IDX  = 9;

    // A10 high during PRECHARGE selects all banks
    localparam int A10_IDX = 10;

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_PREC,
        ST_TRP,
        ST_AREF,
        ST_TRFC,
        ST_MRS,
        ST_TMRD,
        ST_DONE
    } init_state_t;

endpackage

// File: rtl/sdram_init_seq.sv
// sdram_init_seq
// SDRAM power-up initialisation sequencer. After reset it waits the power-up
// time, then issues PRECHARGE-ALL, AREF_NUM auto-refreshes and a LOAD MODE
// REGISTER, each separated by its recovery time, and finally raises flag_init.
// A reinit_req pulse while idle re-runs the sequence without the power-up wait.
// Ports:
//  S_CLK      in   system clock
//  RST_N      in   synchronous active-low reset
//  reinit_req in   1-cycle request to re-run the sequence (ignored while busy)
//  init_cmd   out  {CKE,CS_N,RAS_N,CAS_N,WE_N}, registered
//  init_addr  out  SDRAM address (mode word during MRS, A10 set otherwise)
//  init_ba    out  bank address, tied to 0
//  init_busy  out  high while the sequence runs
//  flag_init  out  initialisation complete (level)
module sdram_init_seq
    import sdram_pkg::*;
#(
    parameter int          CLK_PERIOD_NS = 10,
    parameter int          T_POWERUP_US  = 200,
    parameter int          T_RP_CYC      = 2,
    parameter int          T_RFC_CYC     = 7,
    parameter int          T_MRD_CYC     = 2,
    parameter int          AREF_NUM      = 2,
    parameter int          ADDR_W        = 12,
    parameter int          BA_W          = 2,
    parameter int          CAS_LAT       = 2,
    parameter logic [2:0]  BL_CODE       = 3'b010,
    parameter int          WB_MODE       = 0
) (
    input  logic              S_CLK,
    input  logic              RST_N,
    input  logic              reinit_req,
    output logic [4:0]        init_cmd,
    output logic [ADDR_W-1:0] init_addr,
    output logic [BA_W-1:0]   init_ba,
    output logic              init_busy,
    output logic              flag_init
);

    localparam int POWERUP_CYC = T_POWERUP_US * 1000 / CLK_PERIOD_NS;
    localparam int CNT_W       = $clog2(POWERUP_CYC + 1);

    // Terminal counts of the shared counter; a recovery of N cycles is one
    // command cycle plus N-1 wait cycles counted 0..N-2.
    localparam logic [CNT_W-1:0] PU_LAST   = CNT_W'(POWERUP_CYC - 1);
    localparam logic [CNT_W-1:0] TRP_LAST  = CNT_W'((T_RP_CYC  > 1) ? T_RP_CYC  - 2 : 0);
    localparam logic [CNT_W-1:0] TRFC_LAST = CNT_W'((T_RFC_CYC > 1) ? T_RFC_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] TMRD_LAST = CNT_W'((T_MRD_CYC > 1) ? T_MRD_CYC - 2 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    localparam logic [4:0] AREF_TOTAL = 5'(AREF_NUM);

    localparam int MRS_INT = ((WB_MODE & 1) << MR_WB_IDX)
                           | ((CAS_LAT & 7) << MR_CAS_LSB)
                           | (int'(BL_CODE) << MR_BL_LSB);
    localparam logic [ADDR_W-1:0] MRS_WORD = ADDR_W'(MRS_INT);
    localparam logic [ADDR_W-1:0] A10_WORD = ADDR_W'(1 << A10_IDX);

    init_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        ref_q, ref_d;
    logic [4:0]        cmd_d;
    logic [ADDR_W-1:0] addr_d;
    logic              flag_d;

    assign init_ba = '0;

    // Next-state logic. The counter free-runs (saturating) and is cleared on
    // entry to each timed state. A re-init request parks the FSM in WAIT with
    // the counter already at its terminal value, giving one idle NOP cycle
    // (flag low, busy high) before PRECHARGE instead of the full power-up wait.
    // Outputs are decoded from the next state so they register in step with it.
    always_comb begin
        state_d = state_q;
        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        ref_d   = ref_q;

        case (state_q)
            ST_WAIT: begin
                if (cnt_q == PU_LAST) begin
                    state_d = ST_PREC;
                    cnt_d   = '0;
                end
            end
            ST_PREC: begin
                ref_d   = '0;
                cnt_d   = '0;
                state_d = (T_RP_CYC > 1) ? ST_TRP : ST_AREF;
            end
            ST_TRP: begin
                if (cnt_q == TRP_LAST) begin
                    state_d = ST_AREF;
                end
            end
            ST_AREF: begin
                ref_d = ref_q + 5'd1;
                cnt_d = '0;
                if (T_RFC_CYC > 1) begin
                    state_d = ST_TRFC;
                end else begin
                    state_d = ((ref_q + 5'd1) < AREF_TOTAL) ? ST_AREF : ST_MRS;
                end
            end
            ST_TRFC: begin
                if (cnt_q == TRFC_LAST) begin
                    state_d = (ref_q < AREF_TOTAL) ? ST_AREF : ST_MRS;
                end
            end
            ST_MRS: begin
                cnt_d   = '0;
                state_d = (T_MRD_CYC > 1) ? ST_TMRD : ST_DONE;
            end
            ST_TMRD: begin
                if (cnt_q == TMRD_LAST) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (reinit_req) begin
                    state_d = ST_WAIT;
                    cnt_d   = PU_LAST;
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase

        cmd_d  = CMD_NOP;
        addr_d = A10_WORD;
        case (state_d)
            ST_PREC: cmd_d = CMD_PREC;
            ST_AREF: cmd_d = CMD_AREF;
            ST_MRS: begin
                cmd_d  = CMD_MRS;
                addr_d = MRS_WORD;
            end
            default: cmd_d = CMD_NOP;
        endcase
        flag_d = (state_d == ST_DONE);
    end

    // State, counters and registered outputs; reset restarts the full
    // power-up wait from any point in the sequence.
    always_ff @(posedge S_CLK) begin
        if (!RST_N) begin
            state_q   <= ST_WAIT;
            cnt_q     <= '0;
            ref_q     <= '0;
            init_cmd  <= CMD_NOP;
            init_addr <= A10_WORD;
            flag_init <= 1'b0;
            init_busy <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ref_q     <= ref_d;
            init_cmd  <= cmd_d;
            init_addr <= addr_d;
            flag_init <= flag_d;
            init_busy <= ~flag_d;
        end
    end

endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq
// Three sequencer instances share one clock:
//  A: defaults; reinit after DONE, then a 1-cycle reset mid-sequence
//  B: AREF_NUM=8, T_RFC_CYC=9, CAS_LAT=3, BL_CODE=3'b011
//  C: defaults; reinit pulse between the two AREFs (must be ignored)
// A schedule model predicts every output each cycle; literal pins at fixed
// cycles anchor the model to hand-computed timing.
module tb_sdram_init_seq;

    localparam logic [4:0] NOP  = 5'b10111;
    localparam logic [4:0] PREC = 5'b10010;
    localparam logic [4:0] AREF = 5'b10001;
    localparam logic [4:0] MRS  = 5'b10000;
    localparam int         PU   = 200 * 1000 / 10;
    localparam int         END_CYC = 40070;

    localparam int K_CMD  = 0;
    localparam int K_ADDR = 1;
    localparam int K_FLAG = 2;
    localparam int K_BUSY = 3;

    logic        S_CLK = 1'b0;
    logic        rst_n  [3];
    logic        reinit [3];
    logic [4:0]  cmd_o  [3];
    logic [11:0] addr_o [3];
    logic [1:0]  ba_o   [3];
    logic        flag_o [3];
    logic        busy_o [3];

    int p_trp  [3] = '{2, 2, 2};
    int p_trfc [3] = '{7, 9, 7};
    int p_nref [3] = '{2, 8, 2};
    int p_tmrd [3] = '{2, 2, 2};
    int p_cas  [3] = '{2, 3, 2};
    int p_bl   [3] = '{2, 3, 2};
    int p_wb   [3] = '{0, 0, 0};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit model_valid = 1'b0;

    int          prec_at [3];
    logic [4:0]  e_cmd   [3];
    logic [11:0] e_addr  [3];
    logic        e_flag  [3];

    typedef struct {
        int    t;
        int    inst;
        int    kind;
        int    val;
        string name;
    } pin_t;
    pin_t pins[$];

    always #5 S_CLK = ~S_CLK;

    sdram_init_seq u_a (
        .S_CLK(S_CLK), .RST_N(rst_n[0]), .reinit_req(reinit[0]),
        .init_cmd(cmd_o[0]), .init_addr(addr_o[0]), .init_ba(ba_o[0]),
        .init_busy(busy_o[0]), .flag_init(flag_o[0])
    );

    sdram_init_seq #(
        .AREF_NUM(8), .T_RFC_CYC(9), .CAS_LAT(3), .BL_CODE(3'b011)
    ) u_b (
        .S_CLK(S_CLK), .RST_N(rst_n[1]), .reinit_req(reinit[1]),
        .init_cmd(cmd_o[1]), .init_addr(addr_o[1]), .init_ba(ba_o[1]),
        .init_busy(busy_o[1]), .flag_init(flag_o[1])
    );

    sdram_init_seq u_c (
        .S_CLK(S_CLK), .RST_N(rst_n[2]), .reinit_req(reinit[2]),
        .init_cmd(cmd_o[2]), .init_addr(addr_o[2]), .init_ba(ba_o[2]),
        .init_busy(busy_o[2]), .flag_init(flag_o[2])
    );

    // Schedule model: each instance remembers the cycle its next PRECHARGE is
    // due; everything else is an offset from it. Reset pushes PRECHARGE a full
    // power-up time out; a reinit seen while already done schedules it for the
    // cycle after next.
    always @(posedge S_CLK) begin
        cyc = cyc + 1;
        for (int i = 0; i < 3; i++) begin
            int d, mrs_off, done_off;
            mrs_off  = p_trp[i] + p_nref[i] * p_trfc[i];
            done_off = mrs_off + p_tmrd[i];
            if (!rst_n[i]) begin
                prec_at[i] = cyc + PU;
            end else if (reinit[i] && (cyc - 1 - prec_at[i]) >= done_off) begin
                prec_at[i] = cyc + 1;
            end
            d = cyc - prec_at[i];
            e_cmd[i]  = NOP;
            e_addr[i] = 12'h400;
            if (d == 0) begin
                e_cmd[i] = PREC;
            end else if (d >= p_trp[i] && d < mrs_off && ((d - p_trp[i]) % p_trfc[i]) == 0) begin
                e_cmd[i] = AREF;
            end else if (d == mrs_off) begin
                e_cmd[i]  = MRS;
                e_addr[i] = 12'(p_wb[i] * 512 + p_cas[i] * 16 + p_bl[i]);
            end
            e_flag[i] = (d >= done_off);
        end
        model_valid = 1'b1;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_tests++;
        if (actual != expected) begin
            n_fail++;
            if (n_fail <= 40)
                $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h",
                         name, cyc, actual, expected);
        end
    endtask

    function automatic int pick(input int inst, input int kind);
        case (kind)
            K_CMD:   return int'(cmd_o[inst]);
            K_ADDR:  return int'(addr_o[inst]);
            K_FLAG:  return int'(flag_o[inst]);
            default: return int'(busy_o[inst]);
        endcase
    endfunction

    // Single compare process: model comparison every cycle, literal pins on
    // their own cycles, plus the precharge-all and bank checks.
    always @(negedge S_CLK) begin
        if (model_valid) begin
            for (int i = 0; i < 3; i++) begin
                checkOutput($sformatf("cmd[%0d]", i),  int'(cmd_o[i]),  int'(e_cmd[i]));
                checkOutput($sformatf("addr[%0d]", i), int'(addr_o[i]), int'(e_addr[i]));
                checkOutput($sformatf("ba[%0d]", i),   int'(ba_o[i]),   0);
                checkOutput($sformatf("flag[%0d]", i), int'(flag_o[i]), int'(e_flag[i]));
                checkOutput($sformatf("busy[%0d]", i), int'(busy_o[i]), int'(!e_flag[i]));
                if (cmd_o[i] == PREC)
                    checkOutput($sformatf("a10_prec[%0d]", i), int'(addr_o[i][10]), 1);
            end
            foreach (pins[k]) begin
                if (pins[k].t == cyc)
                    checkOutput(pins[k].name, pick(pins[k].inst, pins[k].kind), pins[k].val);
            end
        end
    end

    function automatic void addPin(input int inst, input int t, input int kind, input int val);
        pin_t p;
        p.t    = t;
        p.inst = inst;
        p.kind = kind;
        p.val  = val;
        p.name = $sformatf("pin_i%0d_k%0d_t%0d", inst, kind, t);
        pins.push_back(p);
    endfunction

    task automatic waitCycle(input int t);
        while (cyc < t) @(negedge S_CLK);
    endtask

    // Drive one input of one instance on the negedge after edge t, so the
    // DUT samples the new value at edge t+1.
    task automatic applyStimulus(input int t, input int inst, input bit is_rst, input bit val);
        waitCycle(t);
        if (is_rst) rst_n[inst] = val;
        else        reinit[inst] = val;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_n[i]  = 1'b0;
            reinit[i] = 1'b0;
        end

        // A: reset, first sequence (last reset edge = 5, PREC at 5+20000)
        addPin(0, 3, K_CMD, NOP);       addPin(0, 3, K_FLAG, 0);   addPin(0, 3, K_BUSY, 1);
        addPin(0, 20004, K_CMD, NOP);   addPin(0, 20005, K_CMD, PREC);
        addPin(0, 20005, K_ADDR, 'h400);
        addPin(0, 20007, K_CMD, AREF);  addPin(0, 20014, K_CMD, AREF);
        addPin(0, 20021, K_CMD, MRS);   addPin(0, 20021, K_ADDR, 'h022);
        addPin(0, 20022, K_FLAG, 0);    addPin(0, 20023, K_FLAG, 1);  addPin(0, 20023, K_BUSY, 0);
        // A: reinit sampled at edge 20033
        addPin(0, 20032, K_FLAG, 1);    addPin(0, 20033, K_FLAG, 0);  addPin(0, 20033, K_BUSY, 1);
        addPin(0, 20033, K_CMD, NOP);   addPin(0, 20034, K_CMD, PREC);
        addPin(0, 20036, K_CMD, AREF);
        // A: reset sampled at edge 20039 (PREC+5), full wait repeats
        addPin(0, 20039, K_CMD, NOP);   addPin(0, 20039, K_FLAG, 0);  addPin(0, 20039, K_BUSY, 1);
        addPin(0, 20043, K_CMD, NOP);   addPin(0, 20051, K_FLAG, 0);
        addPin(0, 40038, K_CMD, NOP);   addPin(0, 40039, K_CMD, PREC);
        addPin(0, 40056, K_FLAG, 0);    addPin(0, 40057, K_FLAG, 1);

        // B: eight AREFs 9 cycles apart, MRS word 0x033
        addPin(1, 20005, K_CMD, PREC);
        for (int k = 0; k < 8; k++) begin
            addPin(1, 20007 + 9 * k, K_CMD, AREF);
            addPin(1, 20008 + 9 * k, K_CMD, NOP);
        end
        addPin(1, 20078, K_CMD, NOP);   addPin(1, 20079, K_CMD, MRS);
        addPin(1, 20079, K_ADDR, 'h033);
        addPin(1, 20080, K_FLAG, 0);    addPin(1, 20081, K_FLAG, 1);

        // C: reinit at PREC+5 is ignored, timing identical to A's first run
        addPin(2, 20005, K_CMD, PREC);  addPin(2, 20007, K_CMD, AREF);
        addPin(2, 20010, K_FLAG, 0);    addPin(2, 20010, K_BUSY, 1);
        addPin(2, 20011, K_CMD, NOP);   addPin(2, 20014, K_CMD, AREF);
        addPin(2, 20021, K_CMD, MRS);   addPin(2, 20021, K_ADDR, 'h022);
        addPin(2, 20023, K_FLAG, 1);

        applyStimulus(5, 0, 1'b1, 1'b1);
        applyStimulus(5, 1, 1'b1, 1'b1);
        applyStimulus(5, 2, 1'b1, 1'b1);
        applyStimulus(20009, 2, 1'b0, 1'b1);
        applyStimulus(20010, 2, 1'b0, 1'b0);
        applyStimulus(20032, 0, 1'b0, 1'b1);
        applyStimulus(20033, 0, 1'b0, 1'b0);
        applyStimulus(20038, 0, 1'b1, 1'b0);
        applyStimulus(20039, 0, 1'b1, 1'b1);

        waitCycle(END_CYC);
        @(posedge S_CLK);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
